// File: rtl/wide_pipe_pkg.sv
// wide_pipe_pkg: shared constants and helpers for the wide_pipe slice.
// Holds counter width, payload width ceiling and occupancy width helper.
package wide_pipe_pkg;

  localparam int COUNT_W   = 32;
  localparam int MAX_WIDTH = 1024;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wide_pipe_stage.sv
// wide_pipe_stage: one valid/data register with load enable and flush.
// Ports: clk, rst_n, flush, load_i, valid_i, data_i -> valid_o, data_o.
module wide_pipe_stage
  import wide_pipe_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Data only moves with a real beat so a bubble never clobbers it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/wide_pipe.sv
// wide_pipe: elastic DEPTH-stage pipeline for a WIDTH-bit payload.
// Ports: clk, rst_n, flush, in_valid/in_data/in_ready,
// out_valid/out_data/out_ready, occupancy, and xfer_count
// (only when WIDE_PIPE_COUNT_EN is defined).
module wide_pipe
  import wide_pipe_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [occ_w(DEPTH)-1:0]   occupancy
`ifdef WIDE_PIPE_COUNT_EN
  ,
  output logic [COUNT_W-1:0]        xfer_count
`endif
);

  localparam int OW = occ_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("wide_pipe: DEPTH must be >= 1");
  end
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("wide_pipe: WIDTH out of range");
  end

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  // Ready ripples from the output back to the input, so a stage
  // may load in the same cycle its successor drains.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !vld[i] || rdy[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             pv;
    logic [WIDTH-1:0] pd;
    if (i == 0) begin : g_head
      assign pv = in_valid;
      assign pd = in_data;
    end else begin : g_body
      assign pv = vld[i-1];
      assign pd = dat[i-1];
    end
    wide_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .load_i (rdy[i]),
      .valid_i(pv),
      .data_i (pd),
      .valid_o(vld[i]),
      .data_o (dat[i])
    );
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OW'(vld[i]);
    end
  end

`ifdef WIDE_PIPE_COUNT_EN
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  // Survives flush; only reset clears it. Wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && in_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign xfer_count = cnt_q;
`endif

endmodule
